block_mask_dma: RTL and testbench

- Parametrised successor of the fixed 4-word read/mask/write-back engine.
- Avalon-style CSR slave plus a wide Avalon-style master.
- Copies COUNT wide words from SRC to DST in chunks of up to DEPTH buffered words, ANDing every word with a replicated 32-bit mask.
- Reports busy, done, error and abort status, and raises an optional interrupt.

---
 rtl/block_mask_dma.sv | 224 ++++++++++++++++++++++
 tb/tb_block_mask_dma.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_mask_dma.sv
// rtl/block_mask_dma.sv - chunked read/mask/write-back DMA with CSR slave and wide master
// Copies COUNT wide words SRC->DST through a DEPTH-word buffer, ANDing each with a replicated mask.
module block_mask_dma #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read_n,
  input  logic              csr_write_n,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              m_read_n,
  output logic              m_write_n,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest_n,
  output logic              irq
);

  localparam int IW    = $clog2(DEPTH);
  localparam int ACC_W = IW + 1;
  localparam int LANES = DATA_W / 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
  state_t state, state_nxt;

  logic [31:0]       src, dst, count, mask;
  logic [31:0]       words_done, remaining, mask_l;
  logic              irq_en, done, err, aborted, abort_pend;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ACC_W-1:0]  acc, chunk_n;
  logic [IW-1:0]     nidx;
  logic [DATA_W-1:0] data_buf [DEPTH];
  logic [DATA_W-1:0] mask_rep;
  logic [31:0]       rd_mux;

  logic csr_wr, csr_rd, busy, start_wr, abort_wr, abort_eff;
  logic req_on, accept, last, fin_acc;

  assign csr_wr    = !csr_write_n;
  assign csr_rd    = !csr_read_n && csr_write_n;
  assign busy      = (state != IDLE);
  assign start_wr  = csr_wr && (csr_address == 3'd4) && csr_writedata[0];
  assign abort_wr  = csr_wr && (csr_address == 3'd4) && csr_writedata[2];
  assign abort_eff = abort_pend || (abort_wr && busy);
  assign req_on    = !m_read_n || !m_write_n;
  assign accept    = req_on && m_waitrequest_n;
  assign last      = ((acc + ACC_W'(1)) == chunk_n);
  assign fin_acc   = accept && (last || abort_eff);
  assign nidx      = acc[IW-1:0] + IW'(1);
  assign mask_rep  = {LANES{mask_l}};
  assign irq       = done && irq_en;

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      3'd0: rd_mux = src;
      3'd1: rd_mux = dst;
      3'd2: rd_mux = count;
      3'd3: rd_mux = mask;
      3'd4: rd_mux = {30'd0, irq_en, 1'b0};
      3'd5: rd_mux = {28'd0, aborted, err, done, busy};
      3'd6: rd_mux = words_done;
      default: rd_mux = '0;
    endcase
  end

  // Each phase: one issue cycle (acc==0, idle bus), the accepts, then one decide cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_wr && count != 32'd0) state_nxt = READ;
      READ: begin
        if (req_on) begin
          if (fin_acc && abort_eff) state_nxt = FINISH;
        end else if (abort_eff) begin
          state_nxt = FINISH;
        end else if (acc != '0) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (req_on) begin
          if (fin_acc && abort_eff) state_nxt = FINISH;
        end else if (abort_eff) begin
          state_nxt = FINISH;
        end else if (acc != '0) begin
          state_nxt = (remaining != 32'd0) ? READ : FINISH;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == READ && accept) data_buf[acc[IW-1:0]] <= m_readdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csr_readdata <= '0;
      m_read_n     <= 1'b1;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      src          <= '0;
      dst          <= '0;
      count        <= '0;
      mask         <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      aborted      <= 1'b0;
      abort_pend   <= 1'b0;
      words_done   <= '0;
      remaining    <= '0;
      mask_l       <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      acc          <= '0;
      chunk_n      <= '0;
    end else begin
      if (csr_rd) csr_readdata <= rd_mux;
      if (csr_wr) begin
        case (csr_address)
          3'd0: if (!busy) src <= csr_writedata;
          3'd1: if (!busy) dst <= csr_writedata;
          3'd2: if (!busy) count <= csr_writedata;
          3'd3: if (!busy) mask <= csr_writedata;
          3'd4: irq_en <= csr_writedata[1];
          3'd5: begin
            if (csr_writedata[1]) done    <= 1'b0;
            if (csr_writedata[2]) err     <= 1'b0;
            if (csr_writedata[3]) aborted <= 1'b0;
          end
          default: ;
        endcase
      end
      if (abort_wr && busy) abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start_wr) begin
            if (count == 32'd0) begin
              err  <= 1'b1;
              done <= 1'b0;
            end else begin
              rd_ptr     <= ADDR_W'(src);
              wr_ptr     <= ADDR_W'(dst);
              remaining  <= count;
              mask_l     <= mask;
              words_done <= '0;
              done       <= 1'b0;
              err        <= 1'b0;
              aborted    <= 1'b0;
              abort_pend <= 1'b0;
              acc        <= '0;
            end
          end
        end
        READ: begin
          if (req_on) begin
            if (accept) begin
              acc    <= acc + ACC_W'(1);
              rd_ptr <= rd_ptr + ADDR_W'(STRIDE);
              if (fin_acc) m_read_n <= 1'b1;
              else         m_address <= rd_ptr + ADDR_W'(STRIDE);
            end
          end else if (!abort_eff) begin
            if (acc == '0) begin
              m_read_n  <= 1'b0;
              m_address <= rd_ptr;
              chunk_n   <= (remaining >= 32'(DEPTH)) ? ACC_W'(DEPTH) : ACC_W'(remaining);
            end else begin
              acc <= '0;
            end
          end
        end
        WRITE: begin
          if (req_on) begin
            if (accept) begin
              acc        <= acc + ACC_W'(1);
              wr_ptr     <= wr_ptr + ADDR_W'(STRIDE);
              words_done <= words_done + 32'd1;
              remaining  <= remaining - 32'd1;
              if (fin_acc) begin
                m_write_n <= 1'b1;
              end else begin
                m_address   <= wr_ptr + ADDR_W'(STRIDE);
                m_writedata <= data_buf[nidx] & mask_rep;
              end
            end
          end else if (!abort_eff) begin
            if (acc == '0) begin
              m_write_n   <= 1'b0;
              m_address   <= wr_ptr;
              m_writedata <= data_buf[0] & mask_rep;
            end else begin
              acc <= '0;
            end
          end
        end
        FINISH: begin
          done       <= 1'b1;
          abort_pend <= 1'b0;
          if (abort_eff) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mask_dma.sv
// tb/tb_block_mask_dma.sv - directed self-checking bench for block_mask_dma
module tb_block_mask_dma;

  localparam int DATA_W = 1024;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int STRIDE = 1024;
  localparam int LANES  = DATA_W / 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        csr_address = '0;
  logic              csr_read_n = 1'b1;
  logic              csr_write_n = 1'b1;
  logic [31:0]       csr_writedata = '0;
  logic [31:0]       csr_readdata;
  logic              m_read_n, m_write_n;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_waitrequest_n = 1'b1;
  logic              irq;

  block_mask_dma #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read_n(csr_read_n), .csr_write_n(csr_write_n),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .m_read_n(m_read_n), .m_write_n(m_write_n), .m_address(m_address),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest_n(m_waitrequest_n), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic all_ones = 1'b0;
  int mode = 0;
  int wr_base = 0;

  function automatic logic [DATA_W-1:0] rd_value(input logic [31:0] a);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = (a ^ 32'hC3C3_0000) + 32'(i) * 32'h0100_0193;
    if (all_ones) v = '1;
    return v;
  endfunction

  assign m_readdata = rd_value(32'(m_address));

  typedef struct {
    bit                wr;
    logic [31:0]       addr;
    logic [DATA_W-1:0] data;
  } op_t;
  op_t ops[$];

  int cyc = 0, wr_cnt = 0, last_wr_cyc = 0, irq_cyc = 0;
  int both_low = 0, stab_viol = 0;
  logic stalled = 1'b0, irq_q = 1'b0;
  logic s_rn, s_wn;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      if (!m_read_n && !m_write_n) both_low++;
      if (stalled && (m_address !== s_addr || m_writedata !== s_data ||
                      m_read_n !== s_rn || m_write_n !== s_wn)) stab_viol++;
      stalled = 1'b0;
      if (!m_read_n || !m_write_n) begin
        if (m_waitrequest_n) begin
          ops.push_back('{wr: !m_write_n, addr: 32'(m_address),
                          data: (!m_write_n ? m_writedata : m_readdata)});
          if (!m_write_n) begin
            wr_cnt++;
            last_wr_cyc = cyc;
          end
        end else begin
          stalled = 1'b1;
          s_addr = m_address; s_data = m_writedata; s_rn = m_read_n; s_wn = m_write_n;
        end
      end
      if (irq && !irq_q) irq_cyc = cyc;
    end else begin
      stalled = 1'b0;
    end
    irq_q = irq;
  end

  int stall_ctr = 0;
  always @(negedge clk) begin
    case (mode)
      1: m_waitrequest_n = ($urandom_range(0, 1) == 1);
      2: begin
        if (!m_write_n && wr_cnt == wr_base + 1 && stall_ctr < 3) begin
          m_waitrequest_n = 1'b0;
          stall_ctr++;
        end else begin
          m_waitrequest_n = 1'b1;
        end
      end
      3: m_waitrequest_n = 1'b0;
      default: m_waitrequest_n = 1'b1;
    endcase
    if (mode != 2) stall_ctr = 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write_n = 1'b0;
    @(negedge clk);
    csr_write_n = 1'b1;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_read_n = 1'b0;
    @(negedge clk);
    csr_read_n = 1'b1;
    d = csr_readdata;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n = 0;
    do begin
      csr_rd(3'd5, s);
      n++;
    end while (s[0] && n < 500);
    check("busy_clear", 64'(s[0]), 64'd0);
  endtask

  // Expected order per chunk: all reads, then all writes, masked data from the model.
  task automatic check_job(input int base, input logic [31:0] src, input logic [31:0] dst,
                           input int n, input logic [31:0] msk);
    int k = base;
    check("op_count", 64'(ops.size() - base), 64'(2 * n));
    for (int c = 0; c < n; c += DEPTH) begin
      int m = (n - c < DEPTH) ? n - c : DEPTH;
      for (int j = 0; j < m; j++) begin
        if (k < ops.size())
          check("rd_op", {31'd0, ops[k].wr, ops[k].addr}, {32'd0, src + 32'((c + j) * STRIDE)});
        k++;
      end
      for (int j = 0; j < m; j++) begin
        if (k < ops.size()) begin
          logic [DATA_W-1:0] e;
          int bl = 0;
          bit found = 1'b0;
          e = rd_value(src + 32'((c + j) * STRIDE)) & {LANES{msk}};
          check("wr_op", {31'd0, ops[k].wr, ops[k].addr}, {32'd1, dst + 32'((c + j) * STRIDE)});
          for (int l = 0; l < LANES; l++)
            if (!found && ops[k].data[l*32 +: 32] !== e[l*32 +: 32]) begin
              found = 1'b1;
              bl = l;
            end
          check("wdata", {32'(bl), ops[k].data[bl*32 +: 32]}, {32'(bl), e[bl*32 +: 32]});
        end
        k++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int base, n;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      csr_rd(3'(a), r);
      check($sformatf("reset_csr%0d", a), 64'(r), 64'd0);
    end
    check("reset_rd_n", 64'(m_read_n), 64'd1);
    check("reset_wr_n", 64'(m_write_n), 64'd1);
    check("reset_irq", 64'(irq), 64'd0);

    // Job 1: four words, no stalls, all-ones read data.
    all_ones = 1'b1;
    mode = 0;
    base = ops.size();
    csr_wr(3'd0, 32'h0);
    csr_wr(3'd1, 32'h1_0000);
    csr_wr(3'd2, 32'd4);
    csr_wr(3'd3, 32'h9696_9696);
    csr_wr(3'd4, 32'h3);
    check("lat_rd_n_t", 64'(m_read_n), 64'd1);
    @(negedge clk);
    check("lat_rd_n_t1", 64'(m_read_n), 64'd0);
    check("lat_addr_t1", 64'(m_address), 64'd0);
    wait_idle();
    check_job(base, 32'h0, 32'h1_0000, 4, 32'h9696_9696);
    csr_rd(3'd5, r);
    check("j1_status", 64'(r), 64'h2);
    check("j1_irq", 64'(irq), 64'd1);
    check("j1_irq_lat", 64'(irq_cyc - last_wr_cyc), 64'd3);
    csr_rd(3'd6, r);
    check("j1_words", 64'(r), 64'd4);

    // Job 2: ten words, random stalls, SRC write while busy must be ignored.
    all_ones = 1'b0;
    mode = 1;
    base = ops.size();
    csr_wr(3'd0, 32'h3000);
    csr_wr(3'd1, 32'h8_0000);
    csr_wr(3'd2, 32'd10);
    csr_wr(3'd3, 32'hF0F0_3C3C);
    csr_wr(3'd4, 32'h1);
    csr_wr(3'd0, 32'hDEAD_BEEF);
    wait_idle();
    mode = 0;
    check_job(base, 32'h3000, 32'h8_0000, 10, 32'hF0F0_3C3C);
    csr_rd(3'd6, r);
    check("j2_words", 64'(r), 64'd10);
    csr_rd(3'd0, r);
    check("j2_src_kept", 64'(r), 64'h3000);
    csr_rd(3'd5, r);
    check("j2_status", 64'(r), 64'h2);
    check("j2_irq_off", 64'(irq), 64'd0);

    // COUNT==0 start: error, no bus activity, W1C clears it.
    base = ops.size();
    csr_wr(3'd2, 32'd0);
    csr_wr(3'd4, 32'h1);
    repeat (5) @(negedge clk);
    check("z_no_ops", 64'(ops.size() - base), 64'd0);
    csr_rd(3'd5, r);
    check("z_status", 64'(r), 64'h4);
    csr_wr(3'd5, 32'h4);
    csr_rd(3'd5, r);
    check("z_cleared", 64'(r), 64'h0);

    // Abort during the second write while the slave stalls three cycles.
    base = ops.size();
    wr_base = wr_cnt;
    mode = 2;
    csr_wr(3'd0, 32'h0);
    csr_wr(3'd1, 32'h2_0000);
    csr_wr(3'd2, 32'd4);
    csr_wr(3'd4, 32'h1);
    n = 0;
    while (!(!m_write_n && wr_cnt == wr_base + 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ab_window", 64'(m_write_n), 64'd0);
    csr_wr(3'd4, 32'h4);
    wait_idle();
    repeat (5) @(negedge clk);
    mode = 0;
    check("ab_ops", 64'(ops.size() - base), 64'd6);
    if (ops.size() > 0)
      check("ab_last", {31'd0, ops[ops.size()-1].wr, ops[ops.size()-1].addr}, {32'd1, 32'h2_0400});
    csr_rd(3'd5, r);
    check("ab_status", 64'(r), 64'hA);
    csr_rd(3'd6, r);
    check("ab_words", 64'(r), 64'd2);

    // Reset while a read is stalled.
    mode = 3;
    csr_wr(3'd0, 32'h2000);
    csr_wr(3'd2, 32'd4);
    csr_wr(3'd4, 32'h1);
    repeat (2) @(negedge clk);
    check("rst_pending", 64'(m_read_n), 64'd0);
    check("rst_addr", 64'(m_address), 64'h2000);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_rd_n", 64'(m_read_n), 64'd1);
    reset_n = 1'b1;
    mode = 0;
    csr_rd(3'd5, r);
    check("rst_status", 64'(r), 64'd0);
    csr_rd(3'd0, r);
    check("rst_src", 64'(r), 64'd0);

    check("both_low", 64'(both_low), 64'd0);
    check("stable_stall", 64'(stab_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
